// File: rtl/eu_xbuf_mc_if.sv
// Bus bundle for eu_xbuf_mc: write channels, lookup ports, occupancy and
// the speculative controls that exist only when EU_XBUF_SPEC_FLUSH_EN is defined.
interface eu_xbuf_mc_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [NUM_WR-1:0]        wr_valid_i;
  logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic [NUM_WR-1:0]        wr_success_o;
  logic [NUM_RD-1:0]        rd_valid_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_success_o;
  logic [CNT_W-1:0]         count_o;
`ifdef EU_XBUF_SPEC_FLUSH_EN
  logic                     spec_flush_i;
  logic                     spec_commit_i;
`endif

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
`ifdef EU_XBUF_SPEC_FLUSH_EN
    output spec_flush_i, spec_commit_i,
`endif
    input  wr_success_o, rd_data_o, rd_success_o, count_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
`ifdef EU_XBUF_SPEC_FLUSH_EN
    input  spec_flush_i, spec_commit_i,
`endif
    output wr_success_o, rd_data_o, rd_success_o, count_o
  );
endinterface

// File: rtl/eu_xbuf_mc.sv
// Multi-channel tag-matched operand cross-buffer with registered lookups.
// Define EU_XBUF_SPEC_FLUSH_EN to enable speculative flush/commit on the tag MSB.
module eu_xbuf_mc #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned NUM_WR          = 2,
  parameter int unsigned NUM_RD          = 2,
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 32,
  parameter bit          CONSUME_ON_READ = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  eu_xbuf_mc_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]         valid_q, valid_n, valid_f;
  logic [ADDR_W-1:0]        addr_q [DEPTH];
  logic [ADDR_W-1:0]        addr_n [DEPTH];
  logic [ADDR_W-1:0]        addr_f [DEPTH];
  logic [DATA_W-1:0]        data_q [DEPTH];
  logic [DATA_W-1:0]        data_n [DEPTH];
  logic [NUM_WR-1:0]        wr_ok;
  logic [NUM_RD-1:0]        rd_hit;
  logic [DATA_W-1:0]        rd_word [NUM_RD];
  logic [DEPTH-1:0]         consumed;
  logic [CNT_W-1:0]         count_n;
  logic [NUM_RD-1:0]        rd_success_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]         count_q;

  logic [ADDR_W-1:0]        w_tag;
  logic                     w_found, w_refuse;
  logic [IDX_W-1:0]         w_idx;
  logic [ADDR_W-1:0]        r_tag;
  logic                     r_found;
  logic [IDX_W-1:0]         r_idx;

  // Writes in channel order; later channels see earlier channels' allocations
  always_comb begin
    valid_n  = valid_q;
    addr_n   = addr_q;
    data_n   = data_q;
    wr_ok    = '0;
    w_tag    = '0;
    w_found  = 1'b0;
    w_refuse = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      w_tag   = bus.wr_addr_i[k*ADDR_W +: ADDR_W];
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!w_found && valid_n[i] && (addr_n[i] == w_tag)) begin
          w_found = 1'b1;
          w_idx   = IDX_W'(i);
        end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!w_found && !valid_n[i]) begin
          w_found = 1'b1;
          w_idx   = IDX_W'(i);
        end
      end
`ifdef EU_XBUF_SPEC_FLUSH_EN
      w_refuse = bus.spec_flush_i && w_tag[ADDR_W-1];
`else
      w_refuse = 1'b0;
`endif
      if (bus.wr_valid_i[k] && w_found && !w_refuse) begin
        wr_ok[k]       = 1'b1;
        valid_n[w_idx] = 1'b1;
        addr_n[w_idx]  = w_tag;
        data_n[w_idx]  = bus.wr_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Lookups see pre-edge state only; lowest matching entry services a port
  always_comb begin
    consumed = '0;
    rd_hit   = '0;
    r_tag    = '0;
    r_found  = 1'b0;
    r_idx    = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) rd_word[j] = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      r_tag   = bus.rd_addr_i[j*ADDR_W +: ADDR_W];
      r_found = 1'b0;
      r_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!r_found && valid_q[i] && (addr_q[i] == r_tag)) begin
          r_found = 1'b1;
          r_idx   = IDX_W'(i);
        end
      end
      if (bus.rd_valid_i[j] && r_found && !consumed[r_idx]) begin
        rd_hit[j]  = 1'b1;
        rd_word[j] = data_q[r_idx];
        if (CONSUME_ON_READ) consumed[r_idx] = 1'b1;
      end
    end
  end

  // Consume beats a same-cycle overwrite; flush beats commit
  always_comb begin
    valid_f = valid_n & ~consumed;
    addr_f  = addr_n;
`ifdef EU_XBUF_SPEC_FLUSH_EN
    if (bus.spec_flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_n[i][ADDR_W-1]) valid_f[i] = 1'b0;
      end
    end else if (bus.spec_commit_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) addr_f[i][ADDR_W-1] = 1'b0;
    end
`endif
    count_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) count_n = count_n + CNT_W'(valid_f[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      rd_success_q <= '0;
      rd_data_q    <= '0;
      count_q      <= '0;
    end else begin
      valid_q      <= valid_f;
      rd_success_q <= rd_hit;
      count_q      <= count_n;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
        if (rd_hit[j]) rd_data_q[j*DATA_W +: DATA_W] <= rd_word[j];
      end
    end
  end

  // Tag/data storage is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_f;
    data_q <= data_n;
  end

  assign bus.wr_success_o = reset ? '0 : wr_ok;
  assign bus.rd_success_o = rd_success_q;
  assign bus.rd_data_o    = rd_data_q;
  assign bus.count_o      = count_q;
endmodule

// File: tb/tb_eu_xbuf_mc.sv
// Scoreboard bench for eu_xbuf_mc: a consuming instance and a persistent
// instance receive identical stimulus; expected lookups are queued and popped.
module tb_eu_xbuf_mc;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  eu_xbuf_mc_if #(.DEPTH(8), .NUM_WR(2), .NUM_RD(2), .ADDR_W(8), .DATA_W(32)) bus ();
  eu_xbuf_mc_if #(.DEPTH(8), .NUM_WR(2), .NUM_RD(2), .ADDR_W(8), .DATA_W(32)) bus_p ();

  eu_xbuf_mc #(.DEPTH(8), .NUM_WR(2), .NUM_RD(2), .ADDR_W(8), .DATA_W(32),
               .CONSUME_ON_READ(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  eu_xbuf_mc #(.DEPTH(8), .NUM_WR(2), .NUM_RD(2), .ADDR_W(8), .DATA_W(32),
               .CONSUME_ON_READ(1'b0)) dut_p (.clk(clk), .reset(reset), .bus(bus_p));

  always #5 clk = ~clk;

  typedef struct {
    int          which;
    int          port;
    logic        hit;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_data [2][2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr_valid_i = '0;  bus.wr_addr_i = '0;  bus.wr_data_i = '0;
    bus.rd_valid_i = '0;  bus.rd_addr_i = '0;
    bus_p.wr_valid_i = '0; bus_p.wr_addr_i = '0; bus_p.wr_data_i = '0;
    bus_p.rd_valid_i = '0; bus_p.rd_addr_i = '0;
`ifdef EU_XBUF_SPEC_FLUSH_EN
    bus.spec_flush_i = 1'b0;   bus.spec_commit_i = 1'b0;
    bus_p.spec_flush_i = 1'b0; bus_p.spec_commit_i = 1'b0;
`endif
  endtask

  task automatic wr(input int ch, input logic [7:0] a, input logic [31:0] d);
    bus.wr_valid_i[ch] = 1'b1;  bus.wr_addr_i[ch*8 +: 8] = a;  bus.wr_data_i[ch*32 +: 32] = d;
    bus_p.wr_valid_i[ch] = 1'b1; bus_p.wr_addr_i[ch*8 +: 8] = a; bus_p.wr_data_i[ch*32 +: 32] = d;
  endtask

  // Drive a lookup on both instances and queue the consuming instance's result
  task automatic rd(input int port, input logic [7:0] a, input logic hit,
                    input logic [31:0] d, input string tag);
    exp_t e;
    bus.rd_valid_i[port] = 1'b1;  bus.rd_addr_i[port*8 +: 8] = a;
    bus_p.rd_valid_i[port] = 1'b1; bus_p.rd_addr_i[port*8 +: 8] = a;
    e.which = 0; e.port = port; e.hit = hit; e.data = d; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic exp_p(input int port, input logic hit, input logic [31:0] d, input string tag);
    exp_t e;
    e.which = 1; e.port = port; e.hit = hit; e.data = d; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wr_ok(input string tag, input logic [1:0] exp, input logic [1:0] exp_pers);
    #1;
    check({tag, "_wr"}, 64'(bus.wr_success_o), 64'(exp));
    check({tag, "_wr_p"}, 64'(bus_p.wr_success_o), 64'(exp_pers));
  endtask

  // Advance one edge, retire every queued lookup, then release inputs
  task automatic step();
    exp_t        e;
    logic        s;
    logic [31:0] d;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.which == 0) begin
        s = bus.rd_success_o[e.port];   d = bus.rd_data_o[e.port*32 +: 32];
      end else begin
        s = bus_p.rd_success_o[e.port]; d = bus_p.rd_data_o[e.port*32 +: 32];
      end
      if (e.hit) last_data[e.which][e.port] = e.data;
      check({e.tag, "_hit"}, 64'(s), 64'(e.hit));
      check({e.tag, "_data"}, 64'(d), 64'(last_data[e.which][e.port]));
    end
    idle();
  endtask

  task automatic do_reset();
    wr(0, 8'h55, 32'h55);
    reset = 1'b1;
    #1;
    check("rst_cnt", 64'(bus.count_o), 64'd0);
    check("rst_succ", 64'(bus.rd_success_o), 64'd0);
    check("rst_data", 64'(bus.rd_data_o), 64'd0);
    check("rst_wr", 64'(bus.wr_success_o), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    for (int w = 0; w < 2; w++) for (int p = 0; p < 2; p++) last_data[w][p] = '0;
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    // Mid-run reset clears occupancy and prior tags
    wr(0, 8'h10, 32'h1010); wr(1, 8'h11, 32'h1111); wr_ok("mr1", 2'b11, 2'b11); step();
    wr(0, 8'h12, 32'h1212); step();
    check("mr_cnt3", 64'(bus.count_o), 64'd3);
    rd(1, 8'h11, 1'b1, 32'h1111, "mr_rd11"); step();
    do_reset();
    rd(0, 8'h10, 1'b0, 32'h0, "mr_rd10"); rd(1, 8'h12, 1'b0, 32'h0, "mr_rd12"); step();
    check("mr_cnt0", 64'(bus.count_o), 64'd0);

    // Fill to full, refuse a new tag, overwrite still allowed when full
    for (int c = 0; c < 4; c++) begin
      wr(0, 8'(8'h40 + 2*c), 32'h1000 + 32'(2*c));
      wr(1, 8'(8'h41 + 2*c), 32'h1001 + 32'(2*c));
      wr_ok("fill", 2'b11, 2'b11);
      step();
    end
    check("full_cnt", 64'(bus.count_o), 64'd8);
    wr(0, 8'h21, 32'h2121); wr(1, 8'h40, 32'hBEEF); wr_ok("full_ref", 2'b10, 2'b10); step();
    check("full_cnt2", 64'(bus.count_o), 64'd8);
    // Slot freed by a consume is not visible to a write in the same cycle
    rd(0, 8'h21, 1'b0, 32'h0, "full_rd21"); rd(1, 8'h40, 1'b1, 32'hBEEF, "full_rd40");
    exp_p(1, 1'b1, 32'hBEEF, "full_rd40_p");
    wr(0, 8'h22, 32'h2222); wr_ok("free_same", 2'b00, 2'b00); step();
    check("free_cnt", 64'(bus.count_o), 64'd7);
    check("free_cnt_p", 64'(bus_p.count_o), 64'd8);
    wr(0, 8'h22, 32'h2222); wr_ok("free_next", 2'b01, 2'b00); step();
    check("refill_cnt", 64'(bus.count_o), 64'd8);
    rd(0, 8'h47, 1'b1, 32'h1007, "full_rd47"); step();

    // Duplicate new tag in one cycle, then a consume conflict across ports
    do_reset();
    wr(0, 8'h05, 32'hA); wr(1, 8'h05, 32'hB); wr_ok("dup", 2'b11, 2'b11); step();
    check("dup_cnt", 64'(bus.count_o), 64'd1);
    wr(0, 8'h06, 32'hC); step();
    check("dup_cnt2", 64'(bus.count_o), 64'd2);
    rd(0, 8'h05, 1'b1, 32'hB, "cc_p0"); rd(1, 8'h05, 1'b0, 32'h0, "cc_p1");
    exp_p(0, 1'b1, 32'hB, "cc_p0_p"); exp_p(1, 1'b1, 32'hB, "cc_p1_p"); step();
    check("cc_cnt", 64'(bus.count_o), 64'd1);
    check("cc_cnt_p", 64'(bus_p.count_o), 64'd2);

    // No write-to-read bypass
    do_reset();
    wr(1, 8'h33, 32'h3333); rd(0, 8'h33, 1'b0, 32'h0, "byp_same"); step();
    check("byp_cnt", 64'(bus.count_o), 64'd1);
    rd(0, 8'h33, 1'b1, 32'h3333, "byp_next"); step();
    check("byp_cnt2", 64'(bus.count_o), 64'd0);

    // Overwrite of an entry consumed the same cycle: consume wins
    wr(0, 8'h77, 32'h7001); step();
    wr(0, 8'h77, 32'h7002); rd(1, 8'h77, 1'b1, 32'h7001, "ow_rd");
    exp_p(1, 1'b1, 32'h7001, "ow_rd_p"); wr_ok("ow", 2'b01, 2'b01); step();
    check("ow_cnt", 64'(bus.count_o), 64'd0);
    check("ow_cnt_p", 64'(bus_p.count_o), 64'd2);
    rd(0, 8'h77, 1'b0, 32'h0, "ow_gone"); exp_p(0, 1'b1, 32'h7002, "ow_new_p"); step();

`ifdef EU_XBUF_SPEC_FLUSH_EN
    // Speculative flush drops MSB-tagged entries; commit clears the MSB
    do_reset();
    wr(0, 8'h81, 32'h8181); wr(1, 8'h01, 32'h0101); step();
    check("sp_cnt2", 64'(bus.count_o), 64'd2);
    bus.spec_flush_i = 1'b1; bus_p.spec_flush_i = 1'b1;
    wr(0, 8'h83, 32'h8383); wr(1, 8'h04, 32'h0404);
    rd(1, 8'h81, 1'b1, 32'h8181, "sp_pre"); wr_ok("sp_ref", 2'b10, 2'b10); step();
    check("sp_cnt_fl", 64'(bus.count_o), 64'd2);
    rd(0, 8'h81, 1'b0, 32'h0, "sp_gone"); rd(1, 8'h01, 1'b1, 32'h0101, "sp_keep"); step();
    check("sp_cnt1", 64'(bus.count_o), 64'd1);
    wr(0, 8'h82, 32'h8282); step();
    bus.spec_commit_i = 1'b1; bus_p.spec_commit_i = 1'b1; step();
    rd(0, 8'h02, 1'b1, 32'h8282, "sp_commit"); step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
